// File: rtl/seg7_bcd_display_pkg.sv
// Shared types and constants for the BCD converter and the multiplexed
// 7-segment scanner.
package seg7_bcd_display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Active-low patterns, bit order g,f,e,d,c,b,a.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // One double-dabble iteration on {hundreds, tens, ones, binary}:
  // add 3 to every BCD nibble >= 5, then shift the whole vector left.
  function automatic logic [19:0] dabble_step(input logic [19:0] sr);
    logic [19:0] t;
    t = sr;
    for (int i = 0; i < 3; i++) begin
      if (t[8+4*i +: 4] >= 4'd5) t[8+4*i +: 4] = t[8+4*i +: 4] + 4'd3;
    end
    return {t[18:0], 1'b0};
  endfunction

endpackage

// File: rtl/seg7_bcd_display_decode.sv
// Combinational BCD digit to active-low 7-segment decoder with blanking.
module seg7_decode
  import seg7_bcd_display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seg7_bcd_display.sv
// 8-bit binary to 3-digit BCD converter (sequential double-dabble) driving a
// time-multiplexed, leading-zero-blanked 7-segment display.
module seg7_bcd_display
  import seg7_bcd_display_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  din,
  output logic [11:0] bcd,
  output logic        busy,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRESC_TC = PW'(SCAN_DIV - 1);

  state_t      state, state_next;
  logic [19:0] sr;
  logic [2:0]  iter;
  logic [7:0]  cap;
  logic [7:0]  last;
  logic        valid;
  logic        start, step, finish;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (!valid || din != last) begin
          start      = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (iter == 3'd7) state_next = DONE;
      end
      DONE: begin
        finish     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sr    <= '0;
      iter  <= '0;
      cap   <= '0;
      last  <= '0;
      valid <= 1'b0;
      bcd   <= '0;
      busy  <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      if (start) begin
        sr   <= {12'd0, din};
        cap  <= din;
        iter <= '0;
      end else if (step) begin
        sr   <= dabble_step(sr);
        iter <= iter + 3'd1;
      end
      // bcd and last move together so the display never sees a half result.
      if (finish) begin
        bcd   <= sr[19:8];
        last  <= cap;
        valid <= 1'b1;
      end
    end
  end

  // Display scan: seg and an are both computed from the next digit index
  // and registered on the same edge.
  logic [PW-1:0] presc;
  logic [1:0]    idx, idx_next;
  logic [3:0]    an_next;
  logic [3:0]    digit;
  logic          blank;
  logic [6:0]    seg_dec;

  always_comb begin
    idx_next = idx;
    if (presc == PRESC_TC) idx_next = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    an_next = 4'b1110;
    digit   = bcd[3:0];
    blank   = 1'b0;
    case (idx_next)
      2'd1: begin
        an_next = 4'b1101;
        digit   = bcd[7:4];
        blank   = (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0);
      end
      2'd2: begin
        an_next = 4'b1011;
        digit   = bcd[11:8];
        blank   = (bcd[11:8] == 4'd0);
      end
      default: ;
    endcase
  end

  seg7_decode u_decode (
    .digit (digit),
    .blank (blank),
    .seg   (seg_dec)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      presc <= '0;
      idx   <= 2'd0;
      an    <= 4'b1110;
      seg   <= SEG_0;
    end else begin
      presc <= (presc == PRESC_TC) ? '0 : presc + PW'(1);
      idx   <= idx_next;
      an    <= an_next;
      seg   <= seg_dec;
    end
  end

endmodule

// File: tb/tb_seg7_bcd_display.sv
// Self-checking bench for seg7_bcd_display: conversion latency and results,
// back-to-back input changes, reset abort, and a per-cycle display monitor.
module tb_seg7_bcd_display;

  localparam int SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  din;
  logic [11:0] bcd;
  logic        busy;
  logic [6:0]  seg;
  logic [3:0]  an;

  int checks   = 0;
  int failures = 0;

  int          scan_t = 0;
  logic        mon_en = 1'b0;
  logic [11:0] prev_bcd;
  logic [7:0]  model_last;

  always #5 clk = ~clk;

  seg7_bcd_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .bcd  (bcd),
    .busy (busy),
    .seg  (seg),
    .an   (an)
  );

  // ---------------- reference model ----------------
  function automatic logic [6:0] pattern(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int from_bcd(input logic [11:0] b);
    return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  // pos 0 = ones, 1 = tens, 2 = hundreds; leading zeros suppressed by magnitude.
  function automatic logic [6:0] expect_seg(input logic [11:0] b, input int pos);
    int n;
    n = from_bcd(b);
    if (pos == 1 && n < 10)  return 7'h7F;
    if (pos == 2 && n < 100) return 7'h7F;
    if (pos == 0) return pattern(n % 10);
    if (pos == 1) return pattern((n / 10) % 10);
    return pattern(n / 100);
  endfunction

  // Count of rising edges since the last edge that saw reset.
  always @(posedge clk) begin
    if (!rst) scan_t = 0;
    else      scan_t = scan_t + 1;
  end

  // Per-cycle display monitor: digit rotation and pattern of the previous bcd
  // (seg is a registered decode, so it reflects bcd one cycle earlier).
  always @(negedge clk) begin
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    int pos;
    if (mon_en) begin
      pos    = (scan_t / SCAN_DIV) % 3;
      exp_an = ~(4'b0001 << pos);
      checks++;
      if (an !== exp_an) begin
        failures++;
        $display("FAIL scan_an t=%0d: got %b expected %b", scan_t, an, exp_an);
      end
      exp_seg = (scan_t == 0) ? 7'b1000000 : expect_seg(prev_bcd, pos);
      checks++;
      if (seg !== exp_seg) begin
        failures++;
        $display("FAIL scan_seg t=%0d an=%b: got %b expected %b", scan_t, an, seg, exp_seg);
      end
    end
    prev_bcd = bcd;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- tasks ----------------
  // Waits for one conversion started by the edge after the caller's negedge.
  task automatic conv_wait(input string name, input int exp_val, input logic [11:0] old);
    int bc;
    logic [11:0] at8;
    bc  = 0;
    at8 = old;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (busy) bc++;
      if (j == 8) at8 = bcd;
      if (!busy && bc > 0) break;
    end
    checks++;
    if (bc !== 9) begin
      failures++;
      $display("FAIL %s_busy_len: got %0d expected 9", name, bc);
    end
    checks++;
    if (at8 !== old) begin
      failures++;
      $display("FAIL %s_early_update: got %h expected %h", name, at8, old);
    end
    checks++;
    if (bcd !== to_bcd(exp_val)) begin
      failures++;
      $display("FAIL %s_bcd: got %h expected %h", name, bcd, to_bcd(exp_val));
    end
  endtask

  task automatic run_conv(input logic [7:0] v, input string name);
    logic [11:0] old;
    old = bcd;
    din = v;
    conv_wait(name, int'(v), old);
    model_last = v;
  endtask

  // Explicit digit patterns over a full scan period once seg has caught up.
  task automatic scan_check(input string name, input logic [6:0] h, input logic [6:0] t,
                            input logic [6:0] o);
    logic [6:0] exp;
    @(negedge clk);
    for (int i = 0; i < 3 * SCAN_DIV; i++) begin
      @(negedge clk);
      case (an)
        4'b1110: exp = o;
        4'b1101: exp = t;
        default: exp = h;
      endcase
      checks++;
      if (seg !== exp) begin
        failures++;
        $display("FAIL %s an=%b: got %b expected %b", name, an, seg, exp);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    din = 8'd0;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    checks++;
    if (bcd !== 12'h000) begin failures++; $display("FAIL reset_bcd: got %h expected 000", bcd); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (an !== 4'b1110) begin failures++; $display("FAIL reset_an: got %b expected 1110", an); end
    checks++;
    if (seg !== 7'b1000000) begin failures++; $display("FAIL reset_seg: got %b expected 1000000", seg); end
    rst = 1'b1;
    conv_wait("reset_release", 0, 12'h000);
    model_last = 8'd0;
    scan_check("zero_display", 7'h7F, 7'h7F, 7'b1000000);
  endtask

  task automatic test_digits;
    run_conv(8'd255, "conv_255");
    scan_check("digits_255", 7'b0100100, 7'b0010010, 7'b0010010);
    run_conv(8'd7, "conv_7");
    scan_check("digits_7", 7'h7F, 7'h7F, 7'b1111000);
    run_conv(8'd105, "conv_105");
    scan_check("digits_105", 7'b1111001, 7'b1000000, 7'b0010010);
  endtask

  task automatic test_back_to_back;
    logic [11:0] old, b8, b9, b18, b19;
    logic busy9, busy10, stray;
    old   = bcd;
    din   = 8'd10;
    stray = 1'b0;
    b8 = 'x; b9 = 'x; b18 = 'x; b19 = 'x; busy9 = 'x; busy10 = 'x;
    for (int j = 0; j < 24; j++) begin
      @(negedge clk);
      if (j == 2) din = 8'd200;
      if (j == 8)  b8 = bcd;
      if (j == 9)  begin b9 = bcd; busy9 = busy; end
      if (j == 10) busy10 = busy;
      if (j == 18) b18 = bcd;
      if (j == 19) b19 = bcd;
      if (bcd !== old && bcd !== 12'h010 && bcd !== 12'h200) stray = 1'b1;
    end
    checks++;
    if (b8 !== old) begin failures++; $display("FAIL b2b_before: got %h expected %h", b8, old); end
    checks++;
    if (b9 !== 12'h010) begin failures++; $display("FAIL b2b_first: got %h expected 010", b9); end
    checks++;
    if (busy9 !== 1'b0) begin failures++; $display("FAIL b2b_gap_busy: got %b expected 0", busy9); end
    checks++;
    if (busy10 !== 1'b1) begin failures++; $display("FAIL b2b_restart_busy: got %b expected 1", busy10); end
    checks++;
    if (b18 !== 12'h010) begin failures++; $display("FAIL b2b_hold: got %h expected 010", b18); end
    checks++;
    if (b19 !== 12'h200) begin failures++; $display("FAIL b2b_second: got %h expected 200", b19); end
    checks++;
    if (stray !== 1'b0) begin failures++; $display("FAIL b2b_stray_value: got 1 expected 0"); end
    model_last = 8'd200;
  endtask

  task automatic test_hold;
    int highs;
    highs = 0;
    din   = model_last;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      if (busy) highs++;
    end
    checks++;
    if (highs !== 0) begin failures++; $display("FAIL hold_no_conv: got %0d busy cycles expected 0", highs); end
  endtask

  task automatic test_random;
    logic [7:0] v;
    for (int n = 0; n < 12; n++) begin
      v = 8'($urandom_range(0, 255));
      if (v == model_last) v = v + 8'd1;
      run_conv(v, "random");
    end
  endtask

  task automatic test_reset_mid_shift;
    run_conv(8'd123, "pre_abort_123");
    din = 8'd200;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bcd !== 12'h000) begin failures++; $display("FAIL abort_bcd: got %h expected 000", bcd); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b expected 0", busy); end
    rst = 1'b1;
    conv_wait("post_abort", 200, 12'h000);
    model_last = 8'd200;
  endtask

  initial begin
    test_reset();
    test_digits();
    test_back_to_back();
    test_hold();
    test_random();
    test_reset_mid_shift();
    repeat (3 * SCAN_DIV) @(negedge clk);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
